// File: rtl/rns_mod_down_pkg.sv
// rns_mod_down_pkg
//   Shared types for the RNS ModDown stage: residue words, the double-width
//   product word, the ModDown FSM state and a conditional-add modular
//   subtract helper.
package rns_mod_down_pkg;

  localparam int RNS_PRIME_BITS = 32;

  typedef logic [RNS_PRIME_BITS-1:0]   rns_residue_t;
  typedef logic [2*RNS_PRIME_BITS-1:0] wide_rns_residue_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } rns_moddown_state_t;

  // (x - c) mod q for x, c < q. The wrap in the borrow case is harmless:
  // the true result is < q, so the modulo-2^N arithmetic lands on it exactly.
  function automatic rns_residue_t sub_mod(input rns_residue_t x,
                                           input rns_residue_t c,
                                           input rns_residue_t q);
    return (x >= c) ? (x - c) : (x - c + q);
  endfunction

endpackage

// File: rtl/rns_mod_down_modmul.sv
// rns_modmul
//   Combinational modular multiply r = (a * b) mod q with q as a runtime
//   port, so the same block can serve any prime of a basis.
//   a, b : residues (< q)
//   q    : modulus
//   r    : (a * b) % q
module rns_modmul
  import rns_mod_down_pkg::*;
(
  input  rns_residue_t a,
  input  rns_residue_t b,
  input  rns_residue_t q,
  output rns_residue_t r
);

  wide_rns_residue_t prod;

  assign prod = wide_rns_residue_t'(a) * wide_rns_residue_t'(b);
  // Remainder is < q, so it always fits back into a residue word.
  assign r    = rns_residue_t'(prod % wide_rns_residue_t'(q));

endmodule

// File: rtl/rns_mod_down.sv
// rns_mod_down
//   RNS ModDown stage: out_j = (x_j - c_j) * P^-1 mod q_j for every prime of
//   basis Q, one prime per cycle through a single shared modmul.
//   clk, reset        : clock, async active-low reset
//   in_valid/in_ready : accept x_RNSint / conv_RNSint (in_ready only in IDLE)
//   x_RNSint          : original residues over Q
//   conv_RNSint       : fast-base-converted P-part residues over Q
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   output_RNSint     : registered result, meaningful while out_valid
module rns_mod_down
  import rns_mod_down_pkg::*;
#(
  parameter int                           BASIS_LEN = 4,
  parameter rns_residue_t [BASIS_LEN-1:0] Q_BASIS   = {BASIS_LEN{rns_residue_t'(17)}},
  parameter rns_residue_t [BASIS_LEN-1:0] PINV_MODQ = {BASIS_LEN{rns_residue_t'(1)}}
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  rns_residue_t [BASIS_LEN-1:0]   x_RNSint,
  input  rns_residue_t [BASIS_LEN-1:0]   conv_RNSint,
  output logic                           out_valid,
  input  logic                           out_ready,
  output rns_residue_t [BASIS_LEN-1:0]   output_RNSint
);

  localparam int IDX_W = $clog2(BASIS_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BASIS_LEN - 1);

  rns_moddown_state_t           state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  rns_residue_t [BASIS_LEN-1:0] x_q, x_d;
  rns_residue_t [BASIS_LEN-1:0] c_q, c_d;
  rns_residue_t [BASIS_LEN-1:0] out_q, out_d;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;

  rns_residue_t q_sel, pinv_sel, x_sel, c_sel, diff, prod_mod;

  // Per-prime operand muxes. Compare-select instead of a direct index keeps
  // the idx width (sized to reach BASIS_LEN) decoupled from the array bounds.
  always_comb begin
    q_sel    = '0;
    pinv_sel = '0;
    x_sel    = '0;
    c_sel    = '0;
    for (int j = 0; j < BASIS_LEN; j++) begin
      if (idx_q == IDX_W'(j)) begin
        q_sel    = Q_BASIS[j];
        pinv_sel = PINV_MODQ[j];
        x_sel    = x_q[j];
        c_sel    = c_q[j];
      end
    end
    diff = sub_mod(x_sel, c_sel, q_sel);
  end

  rns_modmul u_modmul (
    .a (diff),
    .b (pinv_sel),
    .q (q_sel),
    .r (prod_mod)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    c_d     = c_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d     = x_RNSint;
          c_d     = conv_RNSint;
          idx_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        for (int j = 0; j < BASIS_LEN; j++) begin
          if (idx_q == IDX_W'(j)) out_d[j] = prod_mod;
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (out_ready && out_valid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are flops decoded from the next state, so neither
    // depends combinationally on in_valid / out_ready.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      x_q         <= '0;
      c_q         <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      c_q         <= c_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign output_RNSint = out_q;

endmodule
